// File: rtl/banco_pkg.sv
// Shared constants, sequencer encoding and flattened-port helper for the
// parametrised register file.
package banco_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;
   localparam int NRD_DEF  = 2;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } banco_state_e;

   // Low bit of field k in a vector of equal-width fields packed upward from bit 0.
   function automatic int slice_lo(input int k, input int width);
      return k * width;
   endfunction

endpackage

// File: rtl/banco_chk.sv
// Invariants of the register file: ready is sticky until reset, dropped-write
// pulses only follow a not-ready cycle, and read ports are zero when they must be.
module banco_chk
   import banco_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NRD  = NRD_DEF,
   parameter int AW   = 5
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                ready,
   input  logic                wr_drop,
   input  logic [NRD*AW-1:0]   rs,
   input  logic [NRD*XLEN-1:0] datars
);

   a_ready_sticky : assert property (@(posedge clk_i) disable iff (rst_i)
      ready |=> ready);

   a_drop_after_clear : assert property (@(posedge clk_i) disable iff (rst_i)
      wr_drop |-> $past(!ready));

   for (genvar k = 0; k < NRD; k++) begin : g_port
      localparam int ALO = slice_lo(k, AW);
      localparam int DLO = slice_lo(k, XLEN);

      a_zero_read : assert property (@(posedge clk_i) disable iff (rst_i)
         (!ready || (rs[ALO +: AW] == {AW{1'b0}})) |-> (datars[DLO +: XLEN] == {XLEN{1'b0}}));
   end

endmodule

// File: rtl/banco_rd_port.sv
// One read port of the register file: zero while not ready or for address 0,
// optional same-cycle bypass of the write in flight, else the stored word.
module banco_rd_port
   import banco_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int AW     = 5,
   parameter bit BYPASS = 1'b1
) (
   input  logic            ready,
   input  logic [AW-1:0]   addr,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data,
   input  logic [XLEN-1:0] stored,
   output logic [XLEN-1:0] rd_data
);

   logic addr_zero_s;
   logic byp_hit_s;

   // A bypass hit implies wr_addr is non-zero because addr is checked against zero first.
   assign addr_zero_s = (addr == {AW{1'b0}});
   assign byp_hit_s   = BYPASS && wr_en && (wr_addr == addr);

   // Priority mux: not ready, address 0, bypass, storage.
   always_comb begin
      rd_data = {XLEN{1'b0}};
      if (!ready) begin
         rd_data = {XLEN{1'b0}};
      end else if (addr_zero_s) begin
         rd_data = {XLEN{1'b0}};
      end else if (byp_hit_s) begin
         rd_data = wr_data;
      end else begin
         rd_data = stored;
      end
   end

endmodule

// File: rtl/banco_registros_param.sv
// Parametrised register file with hardwired x0, optional write-to-read bypass
// and a one-register-per-cycle clear sequencer started by reset.
module banco_registros_param
   import banco_pkg::*;
#(
   parameter  int XLEN   = XLEN_DEF,
   parameter  int NREG   = NREG_DEF,
   parameter  int NRD    = NRD_DEF,
   parameter  bit BYPASS = 1'b1,
   localparam int AW     = $clog2(NREG)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [AW-1:0]       rd_i,
   input  logic [XLEN-1:0]     datard_i,
   input  logic                wren_i,
   input  logic [NRD*AW-1:0]   rs_i,
   output logic [NRD*XLEN-1:0] datars_o,
   output logic                ready_o,
   output logic                wr_drop_o
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
   localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};

   banco_state_e    state_r;
   banco_state_e    state_nx_s;
   logic [AW-1:0]   clr_cnt_r;
   logic [AW-1:0]   clr_cnt_nx_s;
   logic            ready_s;
   logic            wr_req_s;
   logic            arr_we_s;
   logic [AW-1:0]   arr_addr_s;
   logic [XLEN-1:0] arr_data_s;
   logic            drop_nx_s;
   logic            wr_drop_r;
   logic [XLEN-1:0] regs_r [NREG];

   // Sequencer state and clear counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r   <= ST_CLEAR;
         clr_cnt_r <= CNT_ONE;
      end else begin
         state_r   <= state_nx_s;
         clr_cnt_r <= clr_cnt_nx_s;
      end
   end

   // Next-state logic: walk the counter up to the last register, then run.
   always_comb begin
      state_nx_s   = state_r;
      clr_cnt_nx_s = clr_cnt_r;
      case (state_r)
         ST_CLEAR: begin
            clr_cnt_nx_s = clr_cnt_r + CNT_ONE;
            if (clr_cnt_r == LAST_IDX) begin
               state_nx_s = ST_RUN;
            end else begin
               state_nx_s = ST_CLEAR;
            end
         end
         ST_RUN: begin
            state_nx_s = ST_RUN;
         end
         default: begin
            state_nx_s = ST_CLEAR;
         end
      endcase
   end

   // Array write port: the clear sequencer owns it until the state reaches RUN.
   always_comb begin
      ready_s  = (state_r == ST_RUN);
      wr_req_s = wren_i && (rd_i != {AW{1'b0}});
      if (ready_s) begin
         arr_we_s   = wr_req_s;
         arr_addr_s = rd_i;
         arr_data_s = datard_i;
      end else begin
         arr_we_s   = 1'b1;
         arr_addr_s = clr_cnt_r;
         arr_data_s = {XLEN{1'b0}};
      end
      drop_nx_s = wr_req_s && !ready_s;
   end

   // Storage; entry 0 is never written and never read through a port.
   always_ff @(posedge clk_i) begin
      if (!rst_i && arr_we_s) begin
         regs_r[arr_addr_s] <= arr_data_s;
      end
   end

   // Dropped-write flag; reset clears it even if a write is presented with reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_drop_r <= 1'b0;
      end else begin
         wr_drop_r <= drop_nx_s;
      end
   end

   assign ready_o   = ready_s;
   assign wr_drop_o = wr_drop_r;

   for (genvar k = 0; k < NRD; k++) begin : g_rd_port
      localparam int ALO = slice_lo(k, AW);
      localparam int DLO = slice_lo(k, XLEN);

      logic [AW-1:0] rs_s;

      assign rs_s = rs_i[ALO +: AW];

      banco_rd_port #(
         .XLEN   (XLEN),
         .AW     (AW),
         .BYPASS (BYPASS)
      ) u_port (
         .ready   (ready_s),
         .addr    (rs_s),
         .wr_en   (wren_i),
         .wr_addr (rd_i),
         .wr_data (datard_i),
         .stored  (regs_r[rs_s]),
         .rd_data (datars_o[DLO +: XLEN])
      );
   end

   banco_chk #(
      .XLEN (XLEN),
      .NRD  (NRD),
      .AW   (AW)
   ) u_chk (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .ready   (ready_s),
      .wr_drop (wr_drop_r),
      .rs      (rs_i),
      .datars  (datars_o)
   );

endmodule
